// File: rtl/mac_result_collector.sv
// Collects MAC results through a skid FIFO and writes them to consecutive output-buffer addresses.
// Optional build macro MAC_COLLECT_RELU_EN clamps negative results to zero before they are buffered.
module mac_result_collector #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 10,
  parameter int FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [AddrWidth-1:0] BaseAddr,
  input  logic [AddrWidth-1:0] Count,
  input  logic                 NOPOut,
  input  logic [DataWidth-1:0] DataIn,
  input  logic                 WrReady,
  output logic                 WrEn,
  output logic [AddrWidth-1:0] WrAddr,
  output logic [DataWidth-1:0] WrData,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Overflow
);

  localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [PtrWidth:0]    PtrOne  = 1;
  localparam logic [AddrWidth-1:0] AddrOne = 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [PtrWidth:0]    r_wrPtr;
  logic [PtrWidth:0]    r_rdPtr;
  logic [AddrWidth-1:0] r_addr;
  logic [AddrWidth-1:0] r_count;
  logic [AddrWidth-1:0] r_accCnt;
  logic                 r_overflow;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_pushReq;
  logic                 w_pushOk;
  logic                 w_lastPush;
  logic                 w_start;
  logic [AddrWidth-1:0] w_accNext;
  logic [DataWidth-1:0] w_pushData;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty    = (r_wrPtr == r_rdPtr);
  assign w_full     = (r_wrPtr[PtrWidth] != r_rdPtr[PtrWidth]) &&
                      (r_wrPtr[PtrWidth-1:0] == r_rdPtr[PtrWidth-1:0]);
  assign w_pop      = !w_empty && WrReady;
  assign w_pushReq  = (r_state == COLLECT) && !NOPOut;
  assign w_pushOk   = w_pushReq && (!w_full || w_pop);
  assign w_accNext  = r_accCnt + AddrOne;
  assign w_lastPush = w_pushReq && (w_accNext == r_count);
  assign w_start    = (r_state == IDLE) && Start;

`ifdef MAC_COLLECT_RELU_EN
  assign w_pushData = DataIn[DataWidth-1] ? '0 : DataIn;
`else
  assign w_pushData = DataIn;
`endif

  assign WrEn     = !w_empty;
  assign WrData   = r_mem[r_rdPtr[PtrWidth-1:0]];
  assign WrAddr   = r_addr;
  assign Overflow = r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    Busy        = 1'b1;
    Done        = 1'b0;
    case (r_state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          w_nextState = (Count == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (w_lastPush) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_empty) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        Done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Dropped pushes still advance the accept counter so a job always terminates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_addr     <= '0;
      r_count    <= '0;
      r_accCnt   <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_addr     <= BaseAddr;
      r_count    <= Count;
      r_accCnt   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PtrOne;
        r_addr  <= r_addr + AddrOne;
      end
      if (w_pushReq) begin
        r_accCnt <= w_accNext;
      end
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + PtrOne;
      end else if (w_pushReq) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr[PtrWidth-1:0]] <= w_pushData;
    end
  end

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed self-checking bench for mac_result_collector; expectations follow MAC_COLLECT_RELU_EN.
module tb_mac_result_collector;

  logic       clk;
  logic       reset;
  logic       Start;
  logic [9:0] BaseAddr;
  logic [9:0] Count;
  logic       NOPOut;
  logic [7:0] DataIn;
  logic       WrReady;
  logic       WrEn;
  logic [9:0] WrAddr;
  logic [7:0] WrData;
  logic       Busy;
  logic       Done;
  logic       Overflow;

  int nAsserts = 0;
  int nFails   = 0;

  logic [9:0] wrAddrQ[$];
  logic [7:0] wrDataQ[$];
  int         doneCnt = 0;

  mac_result_collector #(
    .DataWidth(8),
    .AddrWidth(10),
    .FifoDepth(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .BaseAddr(BaseAddr),
    .Count   (Count),
    .NOPOut  (NOPOut),
    .DataIn  (DataIn),
    .WrReady (WrReady),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .Busy    (Busy),
    .Done    (Done),
    .Overflow(Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write transfer and every Done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (WrEn && WrReady) begin
        wrAddrQ.push_back(WrAddr);
        wrDataQ.push_back(WrData);
      end
      if (Done) doneCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic start, input logic [9:0] base, input logic [9:0] cnt,
                               input logic nop, input logic [7:0] data, input logic rdy);
    Start    = start;
    BaseAddr = base;
    Count    = cnt;
    NOPOut   = nop;
    DataIn   = data;
    WrReady  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    Start   = 1'b0;
    NOPOut  = 1'b1;
    WrReady = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!Busy) break;
      @(posedge clk);
      #1;
    end
    checkOutput("idleTimeout", 32'(Busy), 32'h0);
  endtask

  initial begin
    int b;
    int d;
    logic [7:0] negExp;

    Start = 0; BaseAddr = 0; Count = 0; NOPOut = 1; DataIn = 0; WrReady = 1;
    reset = 1'b1;
    #2;
    checkOutput("rstWrEn", 32'(WrEn), 32'h0);
    checkOutput("rstBusy", 32'(Busy), 32'h0);
    checkOutput("rstDone", 32'(Done), 32'h0);
    checkOutput("rstOvf", 32'(Overflow), 32'h0);
    checkOutput("rstAddr", 32'(WrAddr), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic three-result job
    b = wrAddrQ.size(); d = doneCnt;
    applyStimulus(1, 10'h010, 10'd3, 1, 8'h00, 1);
    checkOutput("busyCollect", 32'(Busy), 32'h1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h11, 1);
    checkOutput("latWrEn", 32'(WrEn), 32'h1);
    checkOutput("latWrData", 32'(WrData), 32'h11);
    checkOutput("latWrAddr", 32'(WrAddr), 32'h010);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h22, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h33, 1);
    waitIdle();
    checkOutput("b_nWr", 32'(wrAddrQ.size() - b), 32'd3);
    checkOutput("b_addr0", 32'(wrAddrQ[b]), 32'h010);
    checkOutput("b_addr1", 32'(wrAddrQ[b+1]), 32'h011);
    checkOutput("b_addr2", 32'(wrAddrQ[b+2]), 32'h012);
    checkOutput("b_data0", 32'(wrDataQ[b]), 32'h11);
    checkOutput("b_data1", 32'(wrDataQ[b+1]), 32'h22);
    checkOutput("b_data2", 32'(wrDataQ[b+2]), 32'h33);
    checkOutput("b_done", 32'(doneCnt - d), 32'd1);
    checkOutput("b_ovf", 32'(Overflow), 32'h0);

    // Bubbles interleaved: only valid cycles are written
    b = wrAddrQ.size();
    applyStimulus(1, 10'h100, 10'd4, 1, 8'h00, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'hA0, 1);
    applyStimulus(0, 10'h000, 10'd0, 1, 8'hB1, 1);
    applyStimulus(0, 10'h000, 10'd0, 1, 8'hB2, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'hA3, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'hA4, 1);
    applyStimulus(0, 10'h000, 10'd0, 1, 8'hB5, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'hA6, 1);
    waitIdle();
    checkOutput("nop_nWr", 32'(wrAddrQ.size() - b), 32'd4);
    checkOutput("nop_data0", 32'(wrDataQ[b]), 32'hA0);
    checkOutput("nop_data1", 32'(wrDataQ[b+1]), 32'hA3);
    checkOutput("nop_data2", 32'(wrDataQ[b+2]), 32'hA4);
    checkOutput("nop_data3", 32'(wrDataQ[b+3]), 32'hA6);
    checkOutput("nop_addr3", 32'(wrAddrQ[b+3]), 32'h103);

    // Overflow: six results into a four-entry FIFO with the buffer stalled
    b = wrAddrQ.size(); d = doneCnt;
    applyStimulus(1, 10'h020, 10'd6, 1, 8'h00, 0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 10'h000, 10'd0, 0, 8'(i), 0);
    end
    checkOutput("ovf_set", 32'(Overflow), 32'h1);
    checkOutput("ovf_wrEn", 32'(WrEn), 32'h1);
    checkOutput("ovf_head", 32'(WrData), 32'h01);
    checkOutput("ovf_noWr", 32'(wrAddrQ.size() - b), 32'd0);
    waitIdle();
    checkOutput("ovf_nWr", 32'(wrAddrQ.size() - b), 32'd4);
    checkOutput("ovf_data3", 32'(wrDataQ[b+3]), 32'h04);
    checkOutput("ovf_addr3", 32'(wrAddrQ[b+3]), 32'h023);
    checkOutput("ovf_done", 32'(doneCnt - d), 32'd1);
    checkOutput("ovf_sticky", 32'(Overflow), 32'h1);

    // Address wrap-around
    b = wrAddrQ.size();
    applyStimulus(1, 10'h3FE, 10'd3, 1, 8'h00, 1);
    checkOutput("wrap_ovfClr", 32'(Overflow), 32'h0);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h41, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h42, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h43, 1);
    waitIdle();
    checkOutput("wrap_addr0", 32'(wrAddrQ[b]), 32'h3FE);
    checkOutput("wrap_addr1", 32'(wrAddrQ[b+1]), 32'h3FF);
    checkOutput("wrap_addr2", 32'(wrAddrQ[b+2]), 32'h000);

    // Reset mid-job abandons buffered results
    b = wrAddrQ.size(); d = doneCnt;
    applyStimulus(1, 10'h040, 10'd5, 1, 8'h00, 0);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'hC1, 0);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'hC2, 0);
    reset = 1'b1;
    #1;
    checkOutput("mid_wrEn", 32'(WrEn), 32'h0);
    checkOutput("mid_busy", 32'(Busy), 32'h0);
    checkOutput("mid_done", 32'(Done), 32'h0);
    checkOutput("mid_ovf", 32'(Overflow), 32'h0);
    checkOutput("mid_addr", 32'(WrAddr), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0, 10'h000, 10'd0, 1, 8'h00, 1);
    checkOutput("mid_postWrEn", 32'(WrEn), 32'h0);
    applyStimulus(1, 10'h050, 10'd2, 1, 8'h00, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h5A, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h5B, 1);
    waitIdle();
    checkOutput("mid_nWr", 32'(wrAddrQ.size() - b), 32'd2);
    checkOutput("mid_data0", 32'(wrDataQ[b]), 32'h5A);
    checkOutput("mid_addr1", 32'(wrAddrQ[b+1]), 32'h051);
    checkOutput("mid_doneOnce", 32'(doneCnt - d), 32'd1);

    // Negative-result handling depends on the build macro
`ifdef MAC_COLLECT_RELU_EN
    negExp = 8'h00;
`else
    negExp = 8'h80;
`endif
    b = wrAddrQ.size();
    applyStimulus(1, 10'h060, 10'd2, 1, 8'h00, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h80, 1);
    applyStimulus(0, 10'h000, 10'd0, 0, 8'h7F, 1);
    waitIdle();
    checkOutput("relu_neg", 32'(wrDataQ[b]), 32'(negExp));
    checkOutput("relu_pos", 32'(wrDataQ[b+1]), 32'h7F);

    // Zero-length job goes straight to a Done pulse
    b = wrAddrQ.size(); d = doneCnt;
    applyStimulus(1, 10'h070, 10'd0, 1, 8'h00, 1);
    checkOutput("zero_done", 32'(Done), 32'h1);
    applyStimulus(1, 10'h070, 10'd0, 0, 8'hEE, 1);
    checkOutput("zero_ignStart", 32'(Busy), 32'h0);
    waitIdle();
    checkOutput("zero_nWr", 32'(wrAddrQ.size() - b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/mac_result_collector.md
MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

Interface
REQ-001 SHALL have parameter DataWidth, default 8, result width (matches MAC DataOut).
REQ-002 SHALL have parameter AddrWidth, default 10, output-buffer address width.
REQ-003 SHALL have parameter FifoDepth, default 4, skid FIFO entries, power of 2, >=2.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge; reset is asynchronous, active-high.
REQ-005 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have port Start  in  1  one-cycle request to begin a collection job.
REQ-007 SHALL have port BaseAddr  in  AddrWidth  first write address, sampled on accepted Start.
REQ-008 SHALL have port Count  in  AddrWidth  number of results to collect, sampled on accepted Start.
REQ-009 SHALL have port NOPOut  in  1  from MAC stage; 1 = bubble, 0 = DataIn valid.
REQ-010 SHALL have port DataIn  in  DataWidth  MAC result.
REQ-011 SHALL have port WrReady  in  1  output buffer accepts a write this cycle.
REQ-012 SHALL have port WrEn  out  1  write request; a transfer occurs when WrEn and WrReady are both 1.
REQ-013 SHALL have port WrAddr  out  AddrWidth  write address.
REQ-014 SHALL have port WrData  out  DataWidth  write data.
REQ-015 SHALL have port Busy  out  1  job in progress.
REQ-016 SHALL have port Done  out  1  one-cycle job-complete pulse.
REQ-017 SHALL have port Overflow  out  1  sticky: result dropped because the FIFO was full.

Function
REQ-018 SHALL implement states IDLE, COLLECT, DRAIN, DONE; Busy=1 in all states except IDLE.
REQ-019 In IDLE, Start=1 latches BaseAddr/Count, zeroes the accept counter, and clears Overflow.
REQ-020 With Start accepted: Count=0 -> DONE next cycle; otherwise -> COLLECT.
REQ-021 Start in any state other than IDLE SHALL be ignored.
REQ-022 In COLLECT, each cycle with NOPOut=0 SHALL push DataIn and increment the accept counter, including pushes dropped by REQ-024.
REQ-023 Pushes SHALL stop once the accept counter reaches Count; the transition to DRAIN occurs on the same edge as the last push; NOPOut=0 in IDLE, DRAIN or DONE is ignored.
REQ-024 Push to a full FIFO SHALL be accepted if a write transfer pops on the same cycle; otherwise data is dropped and Overflow is set to 1.
REQ-025 WrEn SHALL equal FIFO non-empty; WrData SHALL be the FIFO head; WrAddr SHALL be the current address.
REQ-026 Each transfer SHALL pop the FIFO and increment WrAddr by 1 modulo 2^AddrWidth (wrap-around, no flag).
REQ-027 Latency: a result pushed at edge N SHALL present WrEn=1 from after edge N when the FIFO was empty; the FIFO SHALL have no combinational path from DataIn to WrData.
REQ-028 DRAIN -> DONE when the FIFO is empty; DONE asserts Done=1 for exactly one cycle, then -> IDLE.
REQ-029 Dropped results SHALL still count toward Count, so the job always terminates.

Reset
REQ-030 While reset=1: state IDLE, FIFO empty, counters 0, WrAddr 0, and WrEn/Busy/Done/Overflow 0, independent of clk.
REQ-031 Reset asserted mid-job SHALL abandon the job; no Done pulse; buffered results are discarded.

Configuration
REQ-032 Macro MAC_COLLECT_RELU_EN: when defined, DataIn with MSB=1 (negative two's complement) SHALL be pushed as 0; when undefined, DataIn SHALL be pushed unmodified; nothing else changes.

Verification
REQ-033 Start, BaseAddr=0x010, Count=3, data 0x11/0x22/0x33 on consecutive cycles, WrReady=1 -> writes to 0x010/0x011/0x012 with those data, Done pulse once, Overflow=0.
REQ-034 Count=4, NOPOut pattern 0,1,1,0,0,1,0 -> exactly 4 writes; bubble data is never written.
REQ-035 FifoDepth=4, WrReady=0, 6 consecutive valid results (Count=6) -> Overflow=1, 4 writes after WrReady=1, then Done.
REQ-036 BaseAddr=0x3FE, Count=3 -> WrAddr sequence 0x3FE, 0x3FF, 0x000.
REQ-037 Reset raised after 2 of 5 results -> all outputs 0 at once, no Done; a fresh Start then runs correctly.
REQ-038 MAC_COLLECT_RELU_EN defined, DataIn=0x80 and 0x7F -> WrData 0x00 and 0x7F; undefined -> 0x80 and 0x7F.
